// File: rtl/ufp_arb_pkg.sv
// Shared constants and result record for the arbitrated ufp multiplier.
package ufp_arb_pkg;

    localparam int unsigned N_DEF   = 4;
    localparam int unsigned WL_DEF  = 16;
    localparam int unsigned QW_DEF  = 8;
    localparam int unsigned LAT_DEF = 3;
    localparam int unsigned IDW_DEF = $clog2(N_DEF);

    typedef struct packed {
        logic [IDW_DEF-1:0] id;
        logic [WL_DEF-1:0]  data;
        logic               sat;
    } ufp_rsp_t;

endpackage

// File: rtl/ufp_mul_pipe.sv
// Rounding/saturating ufp multiplier; LAT-1 register stages, the result FIFO supplies the last.
module ufp_mul_pipe
    import ufp_arb_pkg::*;
#(
    parameter int unsigned WL  = WL_DEF,
    parameter int unsigned QW  = QW_DEF,
    parameter int unsigned LAT = LAT_DEF,
    parameter int unsigned IDW = IDW_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic [WL-1:0]  in_a,
    input  logic [WL-1:0]  in_b,
    input  logic [IDW-1:0] in_id,
    output logic           out_valid,
    output logic [IDW-1:0] out_id,
    output logic [WL-1:0]  out_data,
    output logic           out_sat
);

    localparam int unsigned PW = 2 * WL + 1;
    localparam int unsigned RW = PW - QW;
    localparam int unsigned S  = LAT - 1;

    logic [PW-1:0] prod;
    logic [RW-1:0] rnd;
    logic [WL-1:0] res_data;
    logic          res_sat;

    // Full product, round half up, then clamp to the word range.
    always_comb begin
        prod     = (PW'(in_a) * PW'(in_b)) + (PW'(1) << (QW - 1));
        rnd      = RW'(prod >> QW);
        res_sat  = |rnd[RW-1:WL];
        res_data = res_sat ? '1 : rnd[WL-1:0];
    end

    if (S == 0) begin : g_comb
        assign out_valid = in_valid;
        assign out_id    = in_id;
        assign out_data  = res_data;
        assign out_sat   = res_sat;
    end else begin : g_pipe
        logic [S-1:0]   vld;
        logic [S-1:0]   sat;
        logic [WL-1:0]  dat [S];
        logic [IDW-1:0] ids [S];

        always_ff @(posedge clk) begin
            if (rst) begin
                vld <= '0;
            end else begin
                vld[0] <= in_valid;
                for (int unsigned i = 1; i < S; i++) vld[i] <= vld[i-1];
            end
        end

        // Datapath carries no reset; only the valids qualify it.
        always_ff @(posedge clk) begin
            dat[0] <= res_data;
            ids[0] <= in_id;
            sat[0] <= res_sat;
            for (int unsigned i = 1; i < S; i++) begin
                dat[i] <= dat[i-1];
                ids[i] <= ids[i-1];
                sat[i] <= sat[i-1];
            end
        end

        assign out_valid = vld[S-1];
        assign out_id    = ids[S-1];
        assign out_data  = dat[S-1];
        assign out_sat   = sat[S-1];
    end

endmodule

// File: rtl/ufp_mul_arb.sv
// N-requester round-robin front end to one shared ufp multiplier, credit-gated
// so every accepted operation has a reserved slot in the show-ahead result FIFO.
module ufp_mul_arb
    import ufp_arb_pkg::*;
#(
    parameter int unsigned N   = N_DEF,
    parameter int unsigned WL  = WL_DEF,
    parameter int unsigned QW  = QW_DEF,
    parameter int unsigned LAT = LAT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_valid,
    output logic [N-1:0]         req_ready,
    input  logic [N*WL-1:0]      req_a,
    input  logic [N*WL-1:0]      req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [$clog2(N)-1:0] rsp_id,
    output logic [WL-1:0]        rsp_data,
    output logic                 rsp_sat,
    output logic                 busy
);

    localparam int unsigned IDW = $clog2(N);
    localparam int unsigned D   = LAT + 1;
    localparam int unsigned CW  = $clog2(D + 1);
    localparam int unsigned AW  = $clog2(D);

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [WL-1:0]  data;
        logic           sat;
    } rec_t;

    logic [CW-1:0]  credits;
    logic [IDW-1:0] prio;
    logic [IDW-1:0] gnt_idx;
    logic [IDW-1:0] scan_idx;
    logic           accept;
    logic           pop;

    logic           p_valid;
    logic [IDW-1:0] p_id;
    logic [WL-1:0]  p_data;
    logic           p_sat;

    rec_t           mem [D];
    rec_t           head;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;

    // First valid requester at or after the priority pointer, only with a free credit.
    always_comb begin
        req_ready = '0;
        accept    = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        if (credits != '0) begin
            for (int unsigned k = 0; k < N; k++) begin
                scan_idx = IDW'((32'(prio) + k) % N);
                if (!accept && req_valid[scan_idx]) begin
                    req_ready[scan_idx] = 1'b1;
                    accept              = 1'b1;
                    gnt_idx             = scan_idx;
                end
            end
        end
    end

    assign pop  = rsp_valid & rsp_ready;
    assign busy = credits < CW'(D);

    always_ff @(posedge clk) begin
        if (rst) begin
            credits <= CW'(D);
            prio    <= '0;
        end else begin
            if (accept && !pop)      credits <= credits - CW'(1);
            else if (pop && !accept) credits <= credits + CW'(1);
            if (accept) prio <= (gnt_idx == IDW'(N - 1)) ? '0 : gnt_idx + IDW'(1);
        end
    end

    ufp_mul_pipe #(
        .WL  (WL),
        .QW  (QW),
        .LAT (LAT),
        .IDW (IDW)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (accept),
        .in_a      (req_a[gnt_idx*WL +: WL]),
        .in_b      (req_b[gnt_idx*WL +: WL]),
        .in_id     (gnt_idx),
        .out_valid (p_valid),
        .out_id    (p_id),
        .out_data  (p_data),
        .out_sat   (p_sat)
    );

    // Result FIFO control; occupancy count tells full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (p_valid) wr_ptr <= (wr_ptr == AW'(D - 1)) ? '0 : wr_ptr + AW'(1);
            if (pop)     rd_ptr <= (rd_ptr == AW'(D - 1)) ? '0 : rd_ptr + AW'(1);
            if (p_valid && !pop)      count <= count + CW'(1);
            else if (pop && !p_valid) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (p_valid) mem[wr_ptr] <= '{id: p_id, data: p_data, sat: p_sat};
    end

    // Show-ahead head; outputs forced to zero while empty.
    assign head      = mem[rd_ptr];
    assign rsp_valid = (count != '0);
    assign rsp_id    = rsp_valid ? head.id   : '0;
    assign rsp_data  = rsp_valid ? head.data : '0;
    assign rsp_sat   = rsp_valid ? head.sat  : 1'b0;

    a_fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(p_valid && (count == CW'(D)) && !pop))
        else $error("ufp_mul_arb: write to full result FIFO");

endmodule
